// File: rtl/hilo_mul_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the HI/LO multiply controller slice: operand and
// product widths, the default multiplier timeout, the controller state
// encoding and a helper that sizes the timeout counter.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Operand / register width and full product width.
    localparam int DATA_W = 32;
    localparam int PROD_W = 64;

    // Default number of WAIT cycles granted to the multiplier before the
    // controller gives up and reports a fault.
    localparam int TIMEOUT_DEFAULT = 40;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FAULT  = 2'd3
    } mulState_t;

    // Width of a counter that must hold 0 .. limit-1. A limit of one still
    // needs a one-bit counter so the declaration stays legal.
    function automatic int cntWidth(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/hilo_mul_ctrl_if.sv
// ---------------------------------------------------------------------------
// hilo_mul_ctrl_if
// Handshake bundle between the HI/LO controller and the external multiplier.
//   mul_start   : one-cycle launch pulse (controller -> multiplier)
//   mul_a/mul_b : latched signed operands (controller -> multiplier)
//   mul_done    : one-cycle result strobe (multiplier -> controller)
//   mul_product : signed 64-bit product, valid with mul_done
// Modports: master = controller side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface hilo_mul_ctrl_if;
    import cpu_pkg::*;

    logic              mul_start;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_done;
    logic [PROD_W-1:0] mul_product;

    modport master (
        output mul_start,
        output mul_a,
        output mul_b,
        input  mul_done,
        input  mul_product
    );

    modport slave (
        input  mul_start,
        input  mul_a,
        input  mul_b,
        output mul_done,
        output mul_product
    );

endinterface

// File: rtl/hilo_mul_ctrl_regfile.sv
// ---------------------------------------------------------------------------
// hilo_regfile
// HI/LO register pair. A product write loads both halves at once; the direct
// write ports (mthi/mtlo style) load wr_data into either or both registers.
// If a product write and a direct write ever coincide, the product wins.
// Ports:
//   clk, clear   : clock and asynchronous active-high reset
//   i_prod_we    : load i_product into {HI, LO}
//   i_product    : 64-bit product, stored bit-exact
//   i_hi_we/lo_we: direct write enables
//   i_wr_data    : direct write data
//   o_hi / o_lo  : current register contents
// ---------------------------------------------------------------------------
module hilo_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              i_prod_we,
    input  logic [PROD_W-1:0] i_product,
    input  logic              i_hi_we,
    input  logic              i_lo_we,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    // Product write takes priority; direct writes only land when no product
    // is being stored on the same edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_prod_we) begin
            r_hi <= i_product[PROD_W-1:DATA_W];
            r_lo <= i_product[DATA_W-1:0];
        end else begin
            if (i_hi_we) begin
                r_hi <= i_wr_data;
            end
            if (i_lo_we) begin
                r_lo <= i_wr_data;
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mul_ctrl
// Sequences a multiply on an external multiplier and stores the 64-bit
// result in the HI/LO registers. A request in IDLE latches the operands,
// LAUNCH pulses mul_start, WAIT collects the product or times out into FAULT,
// which sets the sticky err flag. Direct HI/LO writes are honoured in IDLE.
// Ports:
//   clk, clear         : clock and asynchronous active-high reset
//   mul_req, op_a/op_b : multiply request and signed operands (IDLE only)
//   mul_bus            : multiplier handshake (master side)
//   hi_wr, lo_wr       : direct write enables, wr_data is the write data
//   hi_out, lo_out     : HI/LO contents
//   busy               : high in every state other than IDLE
//   prod_valid         : one-cycle pulse after HI/LO take a product
//   err                : sticky timeout flag
// Parameter TIMEOUT: WAIT cycles allowed for mul_done.
// ---------------------------------------------------------------------------
module hilo_mul_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              mul_req,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    hilo_mul_ctrl_if.master   mul_bus,
    input  logic              hi_wr,
    input  logic              lo_wr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              busy,
    output logic              prod_valid,
    output logic              err
);

    localparam int              CNT_W    = cntWidth(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mulState_t         r_state;
    mulState_t         w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_opA;
    logic [DATA_W-1:0] r_opB;
    logic              r_prodValid;
    logic              r_err;

    logic w_latchOps;
    logic w_prodWe;
    logic w_hiWe;
    logic w_loWe;
    logic w_cntClear;
    logic w_cntInc;
    logic w_setErr;

    // State register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and per-state strobes. Direct writes are only forwarded in
    // IDLE, and mul_done is only looked at in WAIT, so strobes arriving in
    // any other state (including a late done after a fault or an abort by
    // clear) fall on the floor. At the last allowed WAIT cycle the counter
    // is not advanced, which keeps it from wrapping when TIMEOUT is a power
    // of two.
    always_comb begin
        w_nextState = r_state;
        w_latchOps  = 1'b0;
        w_prodWe    = 1'b0;
        w_hiWe      = 1'b0;
        w_loWe      = 1'b0;
        w_cntClear  = 1'b0;
        w_cntInc    = 1'b0;
        w_setErr    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_hiWe = hi_wr;
                w_loWe = lo_wr;
                if (mul_req) begin
                    w_latchOps  = 1'b1;
                    w_nextState = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_cntClear  = 1'b1;
                w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_bus.mul_done) begin
                    w_prodWe    = 1'b1;
                    w_nextState = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_nextState = ST_FAULT;
                end else begin
                    w_cntInc = 1'b1;
                end
            end
            ST_FAULT: begin
                w_setErr    = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // WAIT-cycle counter; it holds its value outside LAUNCH/WAIT.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_cnt <= '0;
        end else if (w_cntClear) begin
            r_cnt <= '0;
        end else if (w_cntInc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Operand latch: captured on acceptance and held until the next accepted
    // request, so the multiplier sees stable operands throughout the job.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_opA <= '0;
            r_opB <= '0;
        end else if (w_latchOps) begin
            r_opA <= op_a;
            r_opB <= op_b;
        end
    end

    // prod_valid trails the HI/LO product write by one cycle; err is sticky
    // and only a clear removes it.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_prodValid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_prodValid <= w_prodWe;
            r_err       <= r_err | w_setErr;
        end
    end

    hilo_regfile u_regfile (
        .clk       (clk),
        .clear     (clear),
        .i_prod_we (w_prodWe),
        .i_product (mul_bus.mul_product),
        .i_hi_we   (w_hiWe),
        .i_lo_we   (w_loWe),
        .i_wr_data (wr_data),
        .o_hi      (hi_out),
        .o_lo      (lo_out)
    );

    assign mul_bus.mul_start = (r_state == ST_LAUNCH);
    assign mul_bus.mul_a     = r_opA;
    assign mul_bus.mul_b     = r_opB;
    assign busy              = (r_state != ST_IDLE);
    assign prod_valid        = r_prodValid;
    assign err               = r_err;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_mul_ctrl
// Directed-plus-random bench for hilo_mul_ctrl. The bench plays the
// multiplier itself: it computes each product from the operands it sent and
// keeps its own expected HI/LO/err values.
// ---------------------------------------------------------------------------
module tb_hilo_mul_ctrl;
    import cpu_pkg::*;

    localparam int TIMEOUT = 40;

    logic              clk;
    logic              clear;
    logic              mulReq;
    logic              hiWr;
    logic              loWr;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] wrData;
    logic [DATA_W-1:0] hiOut;
    logic [DATA_W-1:0] loOut;
    logic              busy;
    logic              prodValid;
    logic              err;

    logic [DATA_W-1:0] expHi;
    logic [DATA_W-1:0] expLo;
    logic              expErr;

    int checks = 0;
    int errors = 0;

    hilo_mul_ctrl_if mulBus ();

    hilo_mul_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .clear      (clear),
        .mul_req    (mulReq),
        .op_a       (opA),
        .op_b       (opB),
        .mul_bus    (mulBus),
        .hi_wr      (hiWr),
        .lo_wr      (loWr),
        .wr_data    (wrData),
        .hi_out     (hiOut),
        .lo_out     (loOut),
        .busy       (busy),
        .prod_valid (prodValid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, asserted, reported on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Full multiply transaction. Called away from a clock edge. doneCycle is
    // the WAIT cycle (0-based) in which the bench strobes mul_done. disturb
    // pokes hi_wr and mul_req in WAIT cycle 1; coWrite raises hi_wr together
    // with the request.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int doneCycle, input bit disturb,
                                 input bit coWrite);
        logic [63:0] prod;
        int starts;
        int idleSeen;
        int opsMoved;
        starts   = 0;
        idleSeen = 0;
        opsMoved = 0;
        prod     = longint'($signed(a)) * longint'($signed(b));

        opA    = a;
        opB    = b;
        mulReq = 1'b1;
        if (coWrite) begin
            hiWr   = 1'b1;
            wrData = $urandom;
        end
        @(posedge clk); #1;
        mulReq = 1'b0;
        hiWr   = 1'b0;
        if (coWrite) begin
            expHi = wrData;
            checkOutput("cowrite_hi", 64'(hiOut), 64'(expHi));
        end
        checkOutput("launch_start", 64'(mulBus.mul_start), 64'd1);
        checkOutput("launch_busy", 64'(busy), 64'd1);
        checkOutput("launch_mul_a", 64'(mulBus.mul_a), 64'(a));
        checkOutput("launch_mul_b", 64'(mulBus.mul_b), 64'(b));

        @(posedge clk); #1;
        for (int i = 0; i <= doneCycle; i++) begin
            starts += int'(mulBus.mul_start);
            if (!busy) idleSeen++;
            if (mulBus.mul_a !== a || mulBus.mul_b !== b) opsMoved++;
            if (i == doneCycle) begin
                mulBus.mul_done    = 1'b1;
                mulBus.mul_product = prod;
            end else if (disturb && i == 1) begin
                hiWr   = 1'b1;
                wrData = ~expHi;
                opA    = ~a;
                opB    = ~b;
                mulReq = 1'b1;
            end
            @(posedge clk); #1;
            mulBus.mul_done    = 1'b0;
            mulBus.mul_product = {$urandom, $urandom};
            hiWr   = 1'b0;
            mulReq = 1'b0;
            if (disturb && i == 1) begin
                checkOutput("wait_hiwr_ignored", 64'(hiOut), 64'(expHi));
            end
        end
        {expHi, expLo} = prod;
        checkOutput("wait_extra_start", 64'(starts), 64'd0);
        checkOutput("wait_busy_drop", 64'(idleSeen), 64'd0);
        checkOutput("wait_ops_stable", 64'(opsMoved), 64'd0);
        checkOutput("done_hi", 64'(hiOut), 64'(expHi));
        checkOutput("done_lo", 64'(loOut), 64'(expLo));
        checkOutput("done_busy", 64'(busy), 64'd0);
        checkOutput("done_prod_valid", 64'(prodValid), 64'd1);
        checkOutput("done_err", 64'(err), 64'(expErr));
        @(posedge clk); #1;
        checkOutput("prod_valid_pulse_end", 64'(prodValid), 64'd0);
        checkOutput("idle_hi_hold", 64'(hiOut), 64'(expHi));
        checkOutput("idle_start_low", 64'(mulBus.mul_start), 64'd0);
    endtask

    initial begin
        clear  = 1'b1;
        mulReq = 1'b0;
        hiWr   = 1'b0;
        loWr   = 1'b0;
        opA    = '0;
        opB    = '0;
        wrData = '0;
        mulBus.mul_done    = 1'b0;
        mulBus.mul_product = '0;
        expHi  = '0;
        expLo  = '0;
        expErr = 1'b0;

        // Reset values.
        @(posedge clk); #1;
        checkOutput("rst_hi", 64'(hiOut), 64'd0);
        checkOutput("rst_lo", 64'(loOut), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_start", 64'(mulBus.mul_start), 64'd0);
        checkOutput("rst_prod_valid", 64'(prodValid), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_mul_a", 64'(mulBus.mul_a), 64'd0);
        checkOutput("rst_mul_b", 64'(mulBus.mul_b), 64'd0);

        // 7 * -3 requested on the first edge after clear, done 33 cycles
        // after the start pulse.
        @(negedge clk);
        clear = 1'b0;
        applyStimulus(32'd7, 32'hFFFF_FFFD, 32, 1'b0, 1'b0);
        checkOutput("neg_product_hi", 64'(hiOut), 64'hFFFF_FFFF);
        checkOutput("neg_product_lo", 64'(loOut), 64'hFFFF_FFEB);

        // Largest positive square.
        applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 3, 1'b0, 1'b0);
        checkOutput("max_sq_hi", 64'(hiOut), 64'h3FFF_FFFF);
        checkOutput("max_sq_lo", 64'(loOut), 64'h0000_0001);

        // Done in the first and in the last permitted WAIT cycle.
        applyStimulus(32'h8000_0000, 32'h8000_0000, 0, 1'b0, 1'b0);
        applyStimulus($urandom, $urandom, TIMEOUT - 1, 1'b0, 1'b0);

        // Random operands and latencies.
        for (int n = 0; n < 6; n++) begin
            applyStimulus($urandom, $urandom, int'($urandom_range(TIMEOUT - 1, 0)),
                          1'b0, 1'b0);
        end

        // Direct writes in IDLE: both together, LO alone, then HI = 0x1234.
        hiWr = 1'b1; loWr = 1'b1; wrData = $urandom;
        @(posedge clk); #1;
        hiWr = 1'b0; loWr = 1'b0;
        expHi = wrData; expLo = wrData;
        checkOutput("wr_both_hi", 64'(hiOut), 64'(expHi));
        checkOutput("wr_both_lo", 64'(loOut), 64'(expLo));
        loWr = 1'b1; wrData = $urandom;
        @(posedge clk); #1;
        loWr = 1'b0;
        expLo = wrData;
        checkOutput("wr_lo_lo", 64'(loOut), 64'(expLo));
        checkOutput("wr_lo_hi", 64'(hiOut), 64'(expHi));
        hiWr = 1'b1; wrData = 32'h0000_1234;
        @(posedge clk); #1;
        hiWr = 1'b0;
        expHi = 32'h0000_1234;
        checkOutput("wr_hi_1234", 64'(hiOut), 64'(expHi));

        // hi_wr and a second mul_req during WAIT are both ignored.
        applyStimulus($urandom, $urandom, 6, 1'b1, 1'b0);

        // Direct write together with mul_req lands, then the product wins.
        applyStimulus($urandom, $urandom, 4, 1'b0, 1'b1);

        // Timeout: mul_done never arrives.
        opA = $urandom; opB = $urandom; mulReq = 1'b1;
        @(posedge clk); #1;
        mulReq = 1'b0;
        checkOutput("to_start", 64'(mulBus.mul_start), 64'd1);
        repeat (TIMEOUT) begin
            @(posedge clk); #1;
        end
        checkOutput("to_last_wait_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        checkOutput("to_fault_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        expErr = 1'b1;
        checkOutput("to_idle_busy", 64'(busy), 64'd0);
        checkOutput("to_err", 64'(err), 64'(expErr));
        checkOutput("to_hi_kept", 64'(hiOut), 64'(expHi));
        checkOutput("to_lo_kept", 64'(loOut), 64'(expLo));
        checkOutput("to_prod_valid", 64'(prodValid), 64'd0);
        // A late done must not write HI/LO.
        mulBus.mul_done = 1'b1; mulBus.mul_product = {$urandom, $urandom};
        @(posedge clk); #1;
        mulBus.mul_done = 1'b0;
        checkOutput("late_done_hi", 64'(hiOut), 64'(expHi));
        checkOutput("late_done_lo", 64'(loOut), 64'(expLo));
        checkOutput("late_done_pv", 64'(prodValid), 64'd0);

        // A new multiply does not clear err.
        applyStimulus($urandom, $urandom, 10, 1'b0, 1'b0);
        checkOutput("err_sticky", 64'(err), 64'd1);

        // clear mid-WAIT aborts; the following done is ignored.
        opA = $urandom; opB = $urandom; mulReq = 1'b1;
        @(posedge clk); #1;
        mulReq = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        #2;
        expHi = '0; expLo = '0; expErr = 1'b0;
        checkOutput("clr_busy", 64'(busy), 64'd0);
        checkOutput("clr_hi", 64'(hiOut), 64'd0);
        checkOutput("clr_lo", 64'(loOut), 64'd0);
        checkOutput("clr_err", 64'(err), 64'd0);
        checkOutput("clr_mul_a", 64'(mulBus.mul_a), 64'd0);
        checkOutput("clr_mul_b", 64'(mulBus.mul_b), 64'd0);
        checkOutput("clr_start", 64'(mulBus.mul_start), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        mulBus.mul_done = 1'b1; mulBus.mul_product = {$urandom, $urandom};
        @(posedge clk); #1;
        mulBus.mul_done = 1'b0;
        checkOutput("post_clr_done_hi", 64'(hiOut), 64'd0);
        checkOutput("post_clr_done_lo", 64'(loOut), 64'd0);
        checkOutput("post_clr_done_busy", 64'(busy), 64'd0);
        checkOutput("post_clr_done_pv", 64'(prodValid), 64'd0);

        // Normal operation resumes after the abort.
        applyStimulus($urandom, $urandom, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mul_ctrl.md
HILO_MUL_CTRL -- requirements
Module: hilo_mul_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum WAIT cycles allowed for mul_done.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 mul_req  input  1  control requests a multiply, sampled in IDLE only.
REQ-005 op_a, op_b  input  32 each  signed multiplicand and multiplier, sampled with mul_req.
REQ-006 mul_start  output  1  one-cycle launch pulse to the multiplier.
REQ-007 mul_a, mul_b  output  32 each  latched operands, held stable from LAUNCH until return to IDLE.
REQ-008 mul_done  input  1  multiplier result strobe, one cycle.
REQ-009 mul_product  input  64  signed product, valid when mul_done=1.
REQ-010 hi_wr, lo_wr  input  1 each  direct write enables (mthi/mtlo).
REQ-011 wr_data  input  32  direct write data.
REQ-012 hi_out, lo_out  output  32 each  current HI/LO contents.
REQ-013 busy  output  1  high in every state other than IDLE; control stalls on it.
REQ-014 prod_valid  output  1  one-cycle pulse in the cycle after HI/LO take a product.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 States: IDLE, LAUNCH, WAIT, FAULT; encoding from the shared package.
REQ-017 IDLE and mul_req=1: latch op_a/op_b into mul_a/mul_b, go to LAUNCH.
REQ-018 LAUNCH: mul_start=1 for exactly this cycle, clear the timeout counter, go to WAIT.
REQ-019 WAIT and mul_done=1: HI<=mul_product[63:32], LO<=mul_product[31:0] on that edge, prod_valid=1 next cycle, go to IDLE.
REQ-020 WAIT and mul_done=0: increment the counter; when the counter reaches TIMEOUT-1 without done, go to FAULT.
REQ-021 FAULT, one cycle: set err, leave HI/LO unchanged, go to IDLE.
REQ-022 Latency: mul_req at edge N gives mul_start high in cycle N+1; done at WAIT cycle k gives hi_out/lo_out updated after edge k; busy low in the following cycle.
REQ-023 mul_done outside WAIT is ignored; a late done after FAULT does not write HI/LO.
REQ-024 mul_req while busy=1 is ignored; no queueing.
REQ-025 hi_wr/lo_wr apply only in IDLE and are ignored while busy.
REQ-026 IDLE with hi_wr and mul_req together: direct write lands on that edge; the later product overwrites it.
REQ-027 hi_wr and lo_wr together: both registers take wr_data.
REQ-028 err clears only on clear; a new mul_req does not clear err.
REQ-029 Product is stored bit-exact, with no sign adjustment or truncation.

Reset
REQ-030 clear=1 forces asynchronously: state IDLE; HI, LO, mul_a, mul_b and the counter to 0; mul_start, prod_valid, err and busy to 0.
REQ-031 clear during LAUNCH/WAIT aborts the operation; a subsequent mul_done is ignored (REQ-023).
REQ-032 First mul_req is accepted on the first edge after clear deasserts.

Structure
REQ-033 Shared package cpu_pkg holds the state enum, the TIMEOUT default, and the 32/64-bit width constants.
REQ-034 A single sub-module, hilo_regfile, holds the HI/LO registers, the product write port and the direct write ports, with product-over-direct priority.
REQ-035 The counter is ceil(log2(TIMEOUT)) bits wide and is not exported.

Verification
REQ-036 op_a=7, op_b=-3, done 33 cycles after start with product -21 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, one prod_valid pulse.
REQ-037 op_a=0x7FFFFFFF, op_b=0x7FFFFFFF -> hi_out=0x3FFFFFFF, lo_out=0x00000001.
REQ-038 mul_done never asserted -> FAULT after 40 WAIT cycles, err=1, HI/LO unchanged, busy low in the next cycle.
REQ-039 hi_wr with wr_data=0x1234 in IDLE, then hi_wr in WAIT -> only the first write takes effect; a second mul_req during WAIT produces no second mul_start.
REQ-040 clear pulsed mid-WAIT, then mul_done -> all outputs 0, state IDLE, HI/LO stay 0.
